// File: rtl/proc6_core_if.sv
// Instruction and data memory bus for proc6_core.
// Latency: none, this is wiring only.
// Backpressure: each strobe is held until the memory returns its ack.
interface proc6_core_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [AW-1:0] i_addr;
  logic          i_rd;
  logic          i_ack;
  logic [15:0]   i_data;
  logic [AW-1:0] d_addr;
  logic          d_rd;
  logic          d_wr;
  logic          d_ack;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data;

  // Core side drives addresses, strobes and write data.
  modport master (
    output i_addr, i_rd, d_addr, d_rd, d_wr, w_data,
    input  i_ack, i_data, d_ack, r_data
  );

  // Memory side answers with acks and read data.
  modport slave (
    input  i_addr, i_rd, d_addr, d_rd, d_wr, w_data,
    output i_ack, i_data, d_ack, r_data
  );
endinterface

// File: rtl/proc6_core.sv
// Small multi-cycle accumulator-free processor: fetch, decode, execute FSM.
// Latency: 3 cycles per instruction with zero-wait memory, plus memory wait states.
// Backpressure: FETCH/LOAD/STORE stall with their strobe held until the ack arrives.
module proc6_core #(
  parameter int DW       = 16,
  parameter int RF_DEPTH = 16,
  parameter int AW       = 16
) (
  input  logic         clk,
  input  logic         rst,
  proc6_core_if.master bus,
  output logic         halted,
  output logic         illegal
);

  localparam int IW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

  typedef enum logic [2:0] {
    FETCH, DECODE, LOAD, STORE, ALU, LDC, JMPZ, HALTED
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [DW-1:0] rf [RF_DEPTH];

  logic [3:0]    op;
  logic [IW-1:0] ra;
  logic [IW-1:0] rb;
  logic [IW-1:0] rc;
  logic [7:0]    d;
  logic [DW-1:0] sext_dw;
  logic [AW-1:0] sext_aw;
  logic [DW-1:0] alu_res;

  assign op = ir[15:12];
  assign ra = ir[8 +: IW];
  assign rb = ir[4 +: IW];
  assign rc = ir[0 +: IW];
  assign d  = ir[7:0];

  // Signed casts give sign extension for any width down to 8 bits.
  assign sext_dw = DW'(signed'(d));
  assign sext_aw = AW'(signed'(d));

  // Register reads are combinational, so ra==rb==rc sees pre-write values.
  assign alu_res = (op == 4'd4) ? (rf[rb] - rf[rc]) : (rf[rb] + rf[rc]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state decode; memory states wait for their ack.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (bus.i_ack) state_nxt = DECODE;
      DECODE: begin
        case (op)
          4'd0:       state_nxt = LOAD;
          4'd1:       state_nxt = STORE;
          4'd2, 4'd4: state_nxt = ALU;
          4'd3:       state_nxt = LDC;
          4'd5:       state_nxt = JMPZ;
          4'd6:       state_nxt = HALTED;
          default:    state_nxt = FETCH;
        endcase
      end
      LOAD:   if (bus.d_ack) state_nxt = FETCH;
      STORE:  if (bus.d_ack) state_nxt = FETCH;
      ALU:    state_nxt = FETCH;
      LDC:    state_nxt = FETCH;
      JMPZ:   state_nxt = FETCH;
      HALTED: state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  // Moore outputs: strobes come from state only, so at most one is ever high.
  assign bus.i_rd   = (state == FETCH);
  assign bus.d_rd   = (state == LOAD);
  assign bus.d_wr   = (state == STORE);
  assign bus.i_addr = pc;
  assign bus.d_addr = (bus.d_rd || bus.d_wr) ? AW'(d) : '0;
  assign bus.w_data = bus.d_wr ? rf[ra] : '0;
  assign halted     = (state == HALTED);

  // Datapath: PC, IR, register file and the sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.i_ack) begin
            ir <= bus.i_data;
            pc <= pc + AW'(1);
          end
        end
        DECODE: if (op > 4'd6) illegal <= 1'b1;
        LOAD:   if (bus.d_ack) rf[ra] <= bus.r_data;
        ALU:    rf[ra] <= alu_res;
        LDC:    rf[ra] <= sext_dw;
        // PC already points past the branch, so back off by one.
        JMPZ:   if (rf[ra] == '0) pc <= pc + sext_aw - AW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc6_core.sv
// Directed-vector bench for proc6_core with a behavioural memory responder.
// Latency: checks exact cycle positions of fetch, decode and execute.
// Backpressure: data acks delayed by a programmable count; fetch can be stalled.
module tb_proc6_core;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk;
  logic rst;
  logic halted;
  logic illegal;

  logic [15:0]   imem [256];
  logic [DW-1:0] dmem [256];
  logic          i_hold;
  logic          force_dack;
  int            d_delay;
  int            d_cnt;

  logic [AW-1:0] fetch_q   [$];
  logic [AW-1:0] st_addr_q [$];
  logic [DW-1:0] st_data_q [$];

  int vectors;
  int miscompares;

  proc6_core_if #(.DW(DW), .AW(AW)) bus ();

  proc6_core #(.DW(DW), .RF_DEPTH(16), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: zero-wait fetch unless held, data ack after d_delay cycles.
  always_comb begin
    bus.i_ack  = bus.i_rd & ~i_hold;
    bus.i_data = imem[bus.i_addr[7:0]];
    bus.d_ack  = ((bus.d_rd | bus.d_wr) & (d_cnt >= d_delay)) | force_dack;
    bus.r_data = dmem[bus.d_addr[7:0]];
  end

  // Logs completed fetches and stores; counts data wait cycles.
  always @(posedge clk) begin
    if (rst) begin
      fetch_q.delete();
      st_addr_q.delete();
      st_data_q.delete();
      d_cnt <= 0;
    end else begin
      if (bus.i_rd && bus.i_ack) fetch_q.push_back(bus.i_addr);
      if (bus.d_wr && bus.d_ack) begin
        st_addr_q.push_back(bus.d_addr);
        st_data_q.push_back(bus.w_data);
      end
      if ((bus.d_rd || bus.d_wr) && !bus.d_ack) d_cnt <= d_cnt + 1;
      else d_cnt <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h6000;
  endtask

  task automatic run_until_halt(input int max_cyc);
    int n;
    n = 0;
    while (!halted && n < max_cyc) begin
      step();
      n++;
    end
    vectors++;
    if (halted !== 1'b1) begin
      $display("FAIL halt_timeout: halted=%b required 1 within %0d cycles", halted, max_cyc);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    clear_imem();
    i_hold = 1'b1;
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.i_rd, bus.d_rd, bus.d_wr, halted, illegal} !== 5'b10000) begin
      $display("FAIL reset_flags: i_rd/d_rd/d_wr/halted/illegal=%b required 10000",
               {bus.i_rd, bus.d_rd, bus.d_wr, halted, illegal});
      miscompares++;
    end
    vectors++;
    if (bus.i_addr !== 16'h0 || bus.d_addr !== 16'h0 || bus.w_data !== 16'h0) begin
      $display("FAIL reset_buses: i_addr=%h d_addr=%h w_data=%h required 0 0 0",
               bus.i_addr, bus.d_addr, bus.w_data);
      miscompares++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (bus.i_rd !== 1'b1 || bus.i_addr !== 16'h0) begin
        $display("FAIL fetch_hold_%0d: i_rd=%b i_addr=%h required 1 0000", k, bus.i_rd, bus.i_addr);
        miscompares++;
      end
    end
    i_hold = 1'b0;
    step();
    vectors++;
    if (bus.i_rd !== 1'b0 || bus.i_addr !== 16'h1) begin
      $display("FAIL fetch_release: i_rd=%b i_addr=%h required 0 0001", bus.i_rd, bus.i_addr);
      miscompares++;
    end
  endtask

  task automatic test_program();
    clear_imem();
    imem[0] = 16'h3105;
    imem[1] = 16'h32FD;
    imem[2] = 16'h2312;
    imem[3] = 16'h6000;
    do_reset();
    repeat (10) step();
    vectors++;
    if (halted !== 1'b0) begin
      $display("FAIL halt_cycle11: halted=%b required 0", halted);
      miscompares++;
    end
    step();
    vectors++;
    if (halted !== 1'b1) begin
      $display("FAIL halt_cycle12: halted=%b required 1", halted);
      miscompares++;
    end
    repeat (3) step();
    vectors++;
    if (bus.i_addr !== 16'h4 || {bus.i_rd, bus.d_rd, bus.d_wr} !== 3'b000 || halted !== 1'b1) begin
      $display("FAIL halted_frozen: i_addr=%h strobes=%b halted=%b required 0004 000 1",
               bus.i_addr, {bus.i_rd, bus.d_rd, bus.d_wr}, halted);
      miscompares++;
    end
    vectors++;
    if (dut.rf[3] !== 16'h0002 || dut.rf[2] !== 16'hFFFD || dut.rf[1] !== 16'h0005) begin
      $display("FAIL add_result: r1=%h r2=%h r3=%h required 0005 fffd 0002",
               dut.rf[1], dut.rf[2], dut.rf[3]);
      miscompares++;
    end
  endtask

  task automatic test_load_wait();
    clear_imem();
    imem[0] = 16'h0010;
    imem[1] = 16'h1040;
    dmem[8'h10] = 16'hBEEF;
    d_delay = 4;
    do_reset();
    step();
    vectors++;
    if (bus.d_rd !== 1'b0) begin
      $display("FAIL load_decode: d_rd=%b required 0", bus.d_rd);
      miscompares++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if ({bus.i_rd, bus.d_rd, bus.d_wr} !== 3'b010 || bus.d_addr !== 16'h0010) begin
        $display("FAIL load_wait_%0d: strobes=%b d_addr=%h required 010 0010",
                 k, {bus.i_rd, bus.d_rd, bus.d_wr}, bus.d_addr);
        miscompares++;
      end
    end
    step();
    vectors++;
    if (bus.d_rd !== 1'b0 || bus.i_rd !== 1'b1) begin
      $display("FAIL load_done: d_rd=%b i_rd=%b required 0 1", bus.d_rd, bus.i_rd);
      miscompares++;
    end
    d_delay = 0;
    run_until_halt(50);
    vectors++;
    if (st_addr_q.size() != 1 || st_addr_q[0] !== 16'h0040 || st_data_q[0] !== 16'hBEEF) begin
      $display("FAIL load_value: stores=%0d addr=%h data=%h required 1 0040 beef",
               st_addr_q.size(), (st_addr_q.size() > 0) ? st_addr_q[0] : 16'hxxxx,
               (st_data_q.size() > 0) ? st_data_q[0] : 16'hxxxx);
      miscompares++;
    end
  endtask

  task automatic test_sub_jmpz();
    logic [AW-1:0] exp_f [10];
    exp_f = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd11, 16'd9};
    clear_imem();
    imem[0]  = 16'h3101;
    imem[1]  = 16'h4201;
    imem[2]  = 16'h1250;
    imem[3]  = 16'h5205;
    imem[4]  = 16'h5002;
    imem[6]  = 16'h3409;
    imem[7]  = 16'h4444;
    imem[8]  = 16'h5003;
    imem[11] = 16'h54FE;
    do_reset();
    run_until_halt(100);
    vectors++;
    if (st_data_q.size() != 1 || st_data_q[0] !== 16'hFFFF) begin
      $display("FAIL sub_underflow: stores=%0d data=%h required 1 ffff", st_data_q.size(),
               (st_data_q.size() > 0) ? st_data_q[0] : 16'hxxxx);
      miscompares++;
    end
    vectors++;
    if (fetch_q.size() != 10) begin
      $display("FAIL jmpz_fetch_count: got %0d fetches required 10", fetch_q.size());
      miscompares++;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (fetch_q[i] !== exp_f[i]) begin
          $display("FAIL jmpz_fetch_%0d: addr=%h required %h", i, fetch_q[i], exp_f[i]);
          miscompares++;
        end
      end
    end
    vectors++;
    if (bus.i_addr !== 16'd10 || dut.rf[4] !== 16'h0) begin
      $display("FAIL jmpz_back: pc=%h r4=%h required 000a 0000", bus.i_addr, dut.rf[4]);
      miscompares++;
    end
  endtask

  task automatic test_jmpz_edges();
    clear_imem();
    imem[0] = 16'h5000;
    do_reset();
    repeat (9) step();
    vectors++;
    if (fetch_q.size() != 3 || fetch_q[0] !== 16'h0 || fetch_q[1] !== 16'h0 ||
        fetch_q[2] !== 16'h0 || bus.i_addr !== 16'h0 || halted !== 1'b0) begin
      $display("FAIL jmpz_self: fetches=%0d pc=%h halted=%b required 3 0000 0",
               fetch_q.size(), bus.i_addr, halted);
      miscompares++;
    end
    imem[0] = 16'h50FF;
    do_reset();
    run_until_halt(20);
    vectors++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 16'h0000 || fetch_q[1] !== 16'hFFFF ||
        bus.i_addr !== 16'h0000) begin
      $display("FAIL pc_wrap: fetches=%0d second=%h pc=%h required 2 ffff 0000",
               fetch_q.size(), (fetch_q.size() > 1) ? fetch_q[1] : 16'hxxxx, bus.i_addr);
      miscompares++;
    end
  endtask

  task automatic test_illegal();
    clear_imem();
    imem[0] = 16'h3122;
    imem[1] = 16'h9123;
    imem[2] = 16'h1160;
    do_reset();
    repeat (4) step();
    vectors++;
    if (illegal !== 1'b0) begin
      $display("FAIL illegal_before: illegal=%b required 0", illegal);
      miscompares++;
    end
    step();
    vectors++;
    if (illegal !== 1'b1 || bus.i_rd !== 1'b1 || bus.i_addr !== 16'h2) begin
      $display("FAIL illegal_set: illegal=%b i_rd=%b pc=%h required 1 1 0002",
               illegal, bus.i_rd, bus.i_addr);
      miscompares++;
    end
    run_until_halt(30);
    vectors++;
    if (illegal !== 1'b1 || st_data_q.size() != 1 || st_data_q[0] !== 16'h0022 ||
        st_addr_q[0] !== 16'h0060) begin
      $display("FAIL illegal_nop: illegal=%b stores=%0d data=%h required 1 1 0022",
               illegal, st_data_q.size(), (st_data_q.size() > 0) ? st_data_q[0] : 16'hxxxx);
      miscompares++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (halted !== 1'b0 || illegal !== 1'b0 || bus.i_addr !== 16'h0 || bus.i_rd !== 1'b1) begin
      $display("FAIL reset_from_halt: halted=%b illegal=%b pc=%h i_rd=%b required 0 0 0000 1",
               halted, illegal, bus.i_addr, bus.i_rd);
      miscompares++;
    end
  endtask

  task automatic test_store_reset();
    clear_imem();
    imem[0] = 16'h3507;
    imem[1] = 16'h1520;
    d_delay = 200;
    do_reset();
    repeat (7) step();
    vectors++;
    if (bus.d_wr !== 1'b1 || bus.w_data !== 16'h0007 || bus.d_addr !== 16'h0020 ||
        st_addr_q.size() != 0) begin
      $display("FAIL store_wait: d_wr=%b w_data=%h d_addr=%h stores=%0d required 1 0007 0020 0",
               bus.d_wr, bus.w_data, bus.d_addr, st_addr_q.size());
      miscompares++;
    end
    rst = 1'b1;
    imem[0] = 16'h1521;
    imem[1] = 16'h6000;
    d_delay = 0;
    step();
    rst = 1'b0;
    force_dack = 1'b1;
    vectors++;
    if (bus.d_wr !== 1'b0 || bus.w_data !== 16'h0 || bus.i_addr !== 16'h0 || bus.i_rd !== 1'b1) begin
      $display("FAIL store_abandon: d_wr=%b w_data=%h pc=%h i_rd=%b required 0 0000 0000 1",
               bus.d_wr, bus.w_data, bus.i_addr, bus.i_rd);
      miscompares++;
    end
    step();
    step();
    force_dack = 1'b0;
    run_until_halt(20);
    vectors++;
    if (st_addr_q.size() != 1 || st_addr_q[0] !== 16'h0021 || st_data_q[0] !== 16'h0000) begin
      $display("FAIL rf_cleared: stores=%0d addr=%h data=%h required 1 0021 0000",
               st_addr_q.size(), (st_addr_q.size() > 0) ? st_addr_q[0] : 16'hxxxx,
               (st_data_q.size() > 0) ? st_data_q[0] : 16'hxxxx);
      miscompares++;
    end
    vectors++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 16'h0 || fetch_q[1] !== 16'h1) begin
      $display("FAIL late_ack_ignored: fetches=%0d required 2 at 0000,0001", fetch_q.size());
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    i_hold      = 1'b0;
    force_dack  = 1'b0;
    d_delay     = 0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    test_reset();
    test_program();
    test_load_wait();
    test_sub_jmpz();
    test_jmpz_edges();
    test_illegal();
    test_store_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded 400000 time units");
    $fatal(1);
  end

endmodule
